// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with the EX-side forwarding-select and load-use
// hazard logic. Data fields are carried bit-exact; nothing is computed on them.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] id_pc_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs_addr_i,
    input  logic [REG_AW-1:0] id_rt_addr_i,
    input  logic [REG_AW-1:0] id_rd_addr_i,
    input  logic [7:0]        id_ctrl_i,
    input  logic              exmem_reg_write_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              memwb_reg_write_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_AW-1:0] ex_rs_addr_o,
    output logic [REG_AW-1:0] ex_rt_addr_o,
    output logic [REG_AW-1:0] ex_rd_addr_o,
    output logic [7:0]        ex_ctrl_o,
    output logic              ex_valid_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              hazard_o
);

    // Bit 2 of the control word marks a load (mem_read).
    localparam int CTRL_MEM_READ = 2;

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
    logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
    logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]        ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic              hazard;

    // Forwarding select for one EX source register: EX/MEM beats MEM/WB,
    // register 0 is never forwarded, so 2'b11 cannot occur.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src))
            sel = 2'b10;
        else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src))
            sel = 2'b01;
        return sel;
    endfunction

    // Load-use hazard: a load in EX whose target is read by the ID instruction.
    always_comb begin
        hazard = ctrl_q[CTRL_MEM_READ]
               & (rt_addr_q != '0)
               & ((rt_addr_q == id_rs_addr_i) | (rt_addr_q == id_rt_addr_i));
    end

    // Next-state: flush > stall > hazard bubble > normal load.
    always_comb begin
        pc_d      = pc_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_addr_d = rs_addr_q;
        rt_addr_d = rt_addr_q;
        rd_addr_d = rd_addr_q;
        ctrl_d    = ctrl_q;
        valid_d   = valid_q;
        if (flush_i || (!stall_i && hazard)) begin
            pc_d      = '0;
            rs_data_d = '0;
            rt_data_d = '0;
            imm_d     = '0;
            rs_addr_d = '0;
            rt_addr_d = '0;
            rd_addr_d = '0;
            ctrl_d    = '0;
            valid_d   = 1'b0;
        end else if (!stall_i) begin
            pc_d      = id_pc_i;
            rs_data_d = id_rs_data_i;
            rt_data_d = id_rt_data_i;
            imm_d     = id_imm_i;
            rs_addr_d = id_rs_addr_i;
            rt_addr_d = id_rt_addr_i;
            rd_addr_d = id_rd_addr_i;
            ctrl_d    = id_ctrl_i;
            valid_d   = 1'b1;
        end
    end

    // EX register bank; reset discards any in-flight instruction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rd_addr_q <= '0;
            ctrl_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            rd_addr_q <= rd_addr_d;
            ctrl_q    <= ctrl_d;
            valid_q   <= valid_d;
        end
    end

    // Output mapping and forwarding selects.
    always_comb begin
        ex_pc_o      = pc_q;
        ex_rs_data_o = rs_data_q;
        ex_rt_data_o = rt_data_q;
        ex_imm_o     = imm_q;
        ex_rs_addr_o = rs_addr_q;
        ex_rt_addr_o = rt_addr_q;
        ex_rd_addr_o = rd_addr_q;
        ex_ctrl_o    = ctrl_q;
        ex_valid_o   = valid_q;
        hazard_o     = hazard;
        fwd_a_o      = fwd_sel(rs_addr_q);
        fwd_b_o      = fwd_sel(rt_addr_q);
    end

endmodule
